// File: rtl/alu_pkg.sv
// ALU control shared definitions.
// Operation classes, ALU selects and R-type funct codes.
package alu_pkg;

    localparam logic [1:0] ALUOPT_MEM = 2'b00;
    localparam logic [1:0] ALUOPT_BR  = 2'b01;
    localparam logic [1:0] ALUOPT_R   = 2'b10;
    localparam logic [1:0] ALUOPT_RSV = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [4:0] FUNCT_ADD = 5'b00000;
    localparam logic [4:0] FUNCT_SUB = 5'b00001;
    localparam logic [4:0] FUNCT_AND = 5'b00010;
    localparam logic [4:0] FUNCT_OR  = 5'b00011;

    typedef struct packed {
        logic [1:0] sel;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_control_circuit_if.sv
// ALU control request/response bundle.
// Master drives the decode request, slave returns the select.
interface alu_control_circuit_if;

    logic [4:0] funct;
    logic [1:0] ALUopt;
    logic       in_valid;
    logic [1:0] ALUctrlsignal;
    logic       illegal;
    logic       out_valid;

    modport master (
        output funct, ALUopt, in_valid,
        input  ALUctrlsignal, illegal, out_valid
    );

    modport slave (
        input  funct, ALUopt, in_valid,
        output ALUctrlsignal, illegal, out_valid
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode.
// Unknown or undefined encodings fall back to ADD, flagged illegal.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [4:0] funct,
    input  logic [1:0] ALUopt,
    output dec_t       dec
);

    // Safe default first so every unmatched path lands on ADD/illegal.
    always_comb begin
        dec.sel     = ALU_ADD;
        dec.illegal = 1'b1;
        unique case (1'b1)
            (ALUopt == ALUOPT_MEM): begin
                dec.sel     = ALU_ADD;
                dec.illegal = 1'b0;
            end
            (ALUopt == ALUOPT_BR): begin
                dec.sel     = ALU_SUB;
                dec.illegal = 1'b0;
            end
            (ALUopt == ALUOPT_R): begin
                if (funct[4:2] == 3'b000) begin
                    dec.sel     = funct[1:0];
                    dec.illegal = 1'b0;
                end
            end
            default: begin
                dec.sel     = ALU_ADD;
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_control_circuit.sv
// Registered ALU control decoder.
// One-cycle latency; outputs hold while no input is accepted.
module alu_control_circuit
    import alu_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    alu_control_circuit_if.slave        bus
);

    dec_t dec;

    alu_ctrl_decode u_dec (
        .funct  (bus.funct),
        .ALUopt (bus.ALUopt),
        .dec    (dec)
    );

    // Capture decode on accepted inputs; out_valid pulses per accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ALUctrlsignal <= ALU_ADD;
            bus.illegal       <= 1'b0;
            bus.out_valid     <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.ALUctrlsignal <= dec.sel;
                bus.illegal       <= dec.illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_control_circuit.sv
// Self-checking bench for alu_control_circuit.
// Vector table through a scoreboard plus reset/hold sequences.
module tb_alu_control_circuit;
    import alu_pkg::*;

    typedef struct {
        logic [1:0] op;
        logic [4:0] fn;
        logic [1:0] sel;
        logic       ill;
    } vec_t;

    typedef struct packed {
        logic [1:0] sel;
        logic       ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t tbl[15];

    alu_control_circuit_if bus ();

    alu_control_circuit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] fn,
                        input logic [1:0] sel, input logic ill);
        exp_t e;
        @(negedge clk);
        bus.ALUopt   = op;
        bus.funct    = fn;
        bus.in_valid = 1'b1;
        e.sel = sel;
        e.ill = ill;
        sb.push_back(e);
    endtask

    // Scoreboard: each out_valid pulse retires the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty_on_valid", 4'd1, 4'd0);
            end else begin
                e = sb.pop_front();
                chk("sel", {2'b00, bus.ALUctrlsignal}, {2'b00, e.sel});
                chk("illegal", {3'b000, bus.illegal}, {3'b000, e.ill});
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        tbl[0]  = '{ALUOPT_R,   FUNCT_ADD, ALU_ADD, 1'b0};
        tbl[1]  = '{ALUOPT_R,   FUNCT_SUB, ALU_SUB, 1'b0};
        tbl[2]  = '{ALUOPT_R,   FUNCT_AND, ALU_AND, 1'b0};
        tbl[3]  = '{ALUOPT_R,   FUNCT_OR,  ALU_OR,  1'b0};
        tbl[4]  = '{ALUOPT_MEM, 5'b00001,  ALU_ADD, 1'b0};
        tbl[5]  = '{ALUOPT_MEM, 5'b11111,  ALU_ADD, 1'b0};
        tbl[6]  = '{ALUOPT_BR,  5'b00001,  ALU_SUB, 1'b0};
        tbl[7]  = '{ALUOPT_BR,  5'b11111,  ALU_SUB, 1'b0};
        tbl[8]  = '{ALUOPT_R,   5'b00100,  ALU_ADD, 1'b1};
        tbl[9]  = '{ALUOPT_R,   5'b10011,  ALU_ADD, 1'b1};
        tbl[10] = '{ALUOPT_R,   5'b01011,  ALU_ADD, 1'b1};
        tbl[11] = '{ALUOPT_RSV, 5'b00000,  ALU_ADD, 1'b1};
        tbl[12] = '{ALUOPT_RSV, 5'b00011,  ALU_ADD, 1'b1};
        tbl[13] = '{ALUOPT_RSV, 5'b11111,  ALU_ADD, 1'b1};
        tbl[14] = '{ALUOPT_R,   FUNCT_OR,  ALU_OR,  1'b0};

        rst_n        = 1'b0;
        bus.ALUopt   = ALUOPT_R;
        bus.funct    = FUNCT_OR;
        bus.in_valid = 1'b0;

        #2;
        chk("rst_sel", {2'b00, bus.ALUctrlsignal}, 4'd0);
        chk("rst_ill", {3'b000, bus.illegal}, 4'd0);
        chk("rst_ov", {3'b000, bus.out_valid}, 4'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_sel", {2'b00, bus.ALUctrlsignal}, 4'd0);
        chk("rel_ov", {3'b000, bus.out_valid}, 4'd0);

        for (int i = 0; i < 15; i++)
            send(tbl[i].op, tbl[i].fn, tbl[i].sel, tbl[i].ill);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);

        send(ALUOPT_R, FUNCT_OR, ALU_OR, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ALUopt   = ALUOPT_RSV;
        bus.funct    = 5'b11111;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("hold_sel", {2'b00, bus.ALUctrlsignal}, {2'b00, ALU_OR});
            chk("hold_ill", {3'b000, bus.illegal}, 4'd0);
            chk("hold_ov", {3'b000, bus.out_valid}, 4'd0);
            #2;
            bus.ALUopt = ALUOPT_BR;
            bus.funct  = 5'b00100;
        end

        send(ALUOPT_R, FUNCT_AND, ALU_AND, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_sel", {2'b00, bus.ALUctrlsignal}, 4'd0);
        chk("mid_rst_ill", {3'b000, bus.illegal}, 4'd0);
        chk("mid_rst_ov", {3'b000, bus.out_valid}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_sel", {2'b00, bus.ALUctrlsignal}, 4'd0);
        chk("post_rst_ill", {3'b000, bus.illegal}, 4'd0);
        chk("post_rst_ov", {3'b000, bus.out_valid}, 4'd0);

        @(negedge clk);
        chk("sb_drained", sb.size() > 0 ? 4'd1 : 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
